// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit: registered ALU control decoder, one-cycle latency.
// Optional encoding-legality checking is enabled by defining ALU_CTRL_ILLEGAL_CHK_EN;
// without it only the unused alu_op classes (110/111) are flagged illegal.
module alu_ctrl_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] alu_op,
    input  logic [2:0] fn3,
    input  logic [6:0] imm11_5,
    input  logic       fn7_5,
    output logic [3:0] control_out,
    output logic       out_valid,
    output logic       illegal
);
    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b0001;
    localparam logic [3:0] XOR  = 4'b0010;
    localparam logic [3:0] OR   = 4'b0011;
    localparam logic [3:0] AND  = 4'b0100;
    localparam logic [3:0] SLL  = 4'b0101;
    localparam logic [3:0] SRL  = 4'b0110;
    localparam logic [3:0] SRA  = 4'b0111;
    localparam logic [3:0] SLT  = 4'b1000;
    localparam logic [3:0] SLTU = 4'b1001;
    localparam logic [3:0] NOP  = 4'b1111;

    logic [3:0] w_base;
    logic [3:0] w_code;
    logic       w_unknown;
    logic       w_bad;
    logic       w_illegal;
    logic [3:0] r_control;
    logic       r_valid;
    logic       r_illegal;

    // Shared R/I arithmetic map; alt selects SUB on 000 and SRA on 101.
    function automatic logic [3:0] arith(input logic [2:0] f, input logic alt);
        case (f)
            3'b000:  arith = alt ? SUB : ADD;
            3'b001:  arith = SLL;
            3'b010:  arith = SLT;
            3'b011:  arith = SLTU;
            3'b100:  arith = XOR;
            3'b101:  arith = alt ? SRA : SRL;
            3'b110:  arith = OR;
            default: arith = AND;
        endcase
    endfunction

    // Decode the instruction class into a base operation code.
    always_comb begin
        w_base    = ADD;
        w_unknown = 1'b0;
        case (alu_op)
            3'b000:  w_base = arith(fn3, fn7_5);
            3'b001:  w_base = (fn3 == 3'b101) ? arith(fn3, imm11_5[5]) : arith(fn3, 1'b0);
            3'b100:  w_base = fn3[2] ? (fn3[1] ? SLTU : SLT) : SUB;
            3'b110, 3'b111: begin
                w_base    = NOP;
                w_unknown = 1'b1;
            end
            default: w_base = ADD;
        endcase
    end

`ifdef ALU_CTRL_ILLEGAL_CHK_EN
    // Flag encodings that no supported instruction uses.
    always_comb begin
        w_bad = 1'b0;
        case (alu_op)
            3'b000:  w_bad = fn7_5 && (fn3 != 3'b000) && (fn3 != 3'b101);
            3'b001:  w_bad = ((fn3 == 3'b001) && (imm11_5 != 7'b0000000)) ||
                             ((fn3 == 3'b101) && (imm11_5 != 7'b0000000) && (imm11_5 != 7'b0100000));
            3'b010:  w_bad = (fn3 == 3'b011) || (fn3 == 3'b110) || (fn3 == 3'b111);
            3'b011:  w_bad = fn3[2];
            3'b100:  w_bad = (fn3 == 3'b010) || (fn3 == 3'b011);
            3'b101:  w_bad = (fn3 != 3'b000);
            default: w_bad = 1'b0;
        endcase
    end
`else
    assign w_bad = 1'b0;
`endif

    assign w_illegal = w_unknown | w_bad;
    assign w_code    = w_illegal ? NOP : w_base;

    // Capture the decode on accepted requests; hold results otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_control <= 4'b0000;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_control <= w_code;
                r_illegal <= w_illegal;
            end
        end
    end

    assign control_out = r_control;
    assign out_valid   = r_valid;
    assign illegal     = r_illegal;
endmodule

// File: tb/tb_alu_ctrl_unit.sv
// tb_alu_ctrl_unit: directed vectors for alu_ctrl_unit.
module tb_alu_ctrl_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] alu_op = 3'b000;
    logic [2:0] fn3 = 3'b000;
    logic [6:0] imm11_5 = 7'b0;
    logic       fn7_5 = 1'b0;
    logic [3:0] control_out;
    logic       out_valid;
    logic       illegal;
    int checks = 0;
    int failures = 0;

    alu_ctrl_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_op(alu_op), .fn3(fn3),
        .imm11_5(imm11_5), .fn7_5(fn7_5), .control_out(control_out),
        .out_valid(out_valid), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] ctrl, input logic v, input logic ill);
        checks++;
        assert ({control_out, out_valid, illegal} === {ctrl, v, ill}) else begin
            failures++;
            $error("FAIL %s: ctrl/valid/illegal got %b/%b/%b expected %b/%b/%b",
                   tag, control_out, out_valid, illegal, ctrl, v, ill);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] op, input logic [2:0] f3,
                        input logic [6:0] imm, input logic f7, input logic [3:0] ctrl, input logic ill);
        @(negedge clk);
        in_valid = 1'b1; alu_op = op; fn3 = f3; imm11_5 = imm; fn7_5 = f7;
        @(posedge clk); #1;
        chk(tag, ctrl, 1'b1, ill);
    endtask

    initial begin
        in_valid = 1'b1; alu_op = 3'b111;
        #1 chk("reset_async", 4'b0000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 chk("reset_discard", 4'b0000, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1 chk("post_reset_idle", 4'b0000, 1'b0, 1'b0);
        step("r_sub",     3'b000, 3'b000, 7'h00, 1'b1, 4'b0001, 1'b0);
        step("r_sra",     3'b000, 3'b101, 7'h00, 1'b1, 4'b0111, 1'b0);
        step("r_sltu",    3'b000, 3'b011, 7'h00, 1'b0, 4'b1001, 1'b0);
        step("r_and",     3'b000, 3'b111, 7'h00, 1'b0, 4'b0100, 1'b0);
        step("i_sra",     3'b001, 3'b101, 7'h20, 1'b0, 4'b0111, 1'b0);
        step("i_srl",     3'b001, 3'b101, 7'h00, 1'b0, 4'b0110, 1'b0);
        step("i_add_f7",  3'b001, 3'b000, 7'h00, 1'b1, 4'b0000, 1'b0);
        step("i_sll",     3'b001, 3'b001, 7'h00, 1'b0, 4'b0101, 1'b0);
        step("i_or",      3'b001, 3'b110, 7'h7f, 1'b1, 4'b0011, 1'b0);
        step("br_sltu",   3'b100, 3'b110, 7'h00, 1'b0, 4'b1001, 1'b0);
        step("br_slt",    3'b100, 3'b100, 7'h00, 1'b0, 4'b1000, 1'b0);
        step("br_sub",    3'b100, 3'b001, 7'h00, 1'b0, 4'b0001, 1'b0);
        step("ld_add",    3'b010, 3'b010, 7'h00, 1'b0, 4'b0000, 1'b0);
        step("st_add",    3'b011, 3'b010, 7'h00, 1'b0, 4'b0000, 1'b0);
        step("jmp_add",   3'b101, 3'b000, 7'h00, 1'b0, 4'b0000, 1'b0);
        step("unk_111",   3'b111, 3'b111, 7'h7f, 1'b1, 4'b1111, 1'b1);
        step("unk_110",   3'b110, 3'b000, 7'h00, 1'b0, 4'b1111, 1'b1);
        step("after_unk", 3'b000, 3'b100, 7'h00, 1'b0, 4'b0010, 1'b0);
`ifdef ALU_CTRL_ILLEGAL_CHK_EN
        step("jmp_fn3",   3'b101, 3'b001, 7'h00, 1'b0, 4'b1111, 1'b1);
        step("r_f7_xor",  3'b000, 3'b100, 7'h00, 1'b1, 4'b1111, 1'b1);
        step("br_010",    3'b100, 3'b010, 7'h00, 1'b0, 4'b1111, 1'b1);
`else
        step("jmp_fn3",   3'b101, 3'b001, 7'h00, 1'b0, 4'b0000, 1'b0);
        step("r_f7_xor",  3'b000, 3'b100, 7'h00, 1'b1, 4'b0010, 1'b0);
        step("br_010",    3'b100, 3'b010, 7'h00, 1'b0, 4'b0001, 1'b0);
`endif
        step("last_slt",  3'b000, 3'b010, 7'h00, 1'b0, 4'b1000, 1'b0);
        @(negedge clk); in_valid = 1'b0; alu_op = 3'b111; fn3 = 3'b101;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 chk("hold", 4'b1000, 1'b0, 1'b0);
        end
        step("pre_rst",   3'b111, 3'b000, 7'h00, 1'b0, 4'b1111, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("mid_reset", 4'b0000, 1'b0, 1'b0);
        @(negedge clk); in_valid = 1'b0; rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1 chk("no_stale_pulse", 4'b0000, 1'b0, 1'b0);
        end
        step("post_rst",  3'b000, 3'b110, 7'h00, 1'b0, 4'b0011, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
